// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter width helper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_ASHR = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset, clear and increment.
// Clear has priority over increment; the count sticks at MAX.
module sat_counter #(
  parameter int MAX = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/univ_shift_reg_sync.sv
// WIDTH-bit universal shift register (hold/shift/rotate/arith-shift/load/clear)
// with a saturating count of shifts since the last load, clear or reset.
module univ_shift_reg_sync
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [2:0]                  mode,
  input  logic                        sin_l,
  input  logic                        sin_r,
  input  logic [WIDTH-1:0]            d,
  output logic [WIDTH-1:0]            q,
  output logic                        sout_l,
  output logic                        sout_r,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        empty
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             w_is_shift;
  logic             w_is_reload;
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic [CW-1:0]    w_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (en) begin
      case (mode)
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sin_r};
        MODE_SHR:  r_q <= {sin_l, r_q[WIDTH-1:1]};
        MODE_LOAD: r_q <= d;
        MODE_ROTL: r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROTR: r_q <= {r_q[0], r_q[WIDTH-1:1]};
        MODE_ASHR: r_q <= {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        MODE_CLR:  r_q <= RST_VAL;
        default:   r_q <= r_q;
      endcase
    end
  end

  // Decode is gated by en so an undriven mode while disabled cannot move cnt.
  always_comb begin
    w_is_shift  = 1'b0;
    w_is_reload = 1'b0;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASHR: w_is_shift  = 1'b1;
      MODE_LOAD, MODE_CLR:                                 w_is_reload = 1'b1;
      default: begin
        w_is_shift  = 1'b0;
        w_is_reload = 1'b0;
      end
    endcase
  end

  assign w_cnt_inc = en & w_is_shift;
  assign w_cnt_clr = en & w_is_reload;

  sat_counter #(
    .MAX(WIDTH),
    .CW (CW)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(w_cnt_clr),
    .inc(w_cnt_inc),
    .cnt(w_cnt)
  );

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign cnt    = w_cnt;
  assign empty  = (w_cnt == CW'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg_sync.sv
// Directed plus randomized bench for univ_shift_reg_sync (WIDTH=8) against an
// arithmetic reference model of the register and its shift counter.
module tb_univ_shift_reg_sync;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] cnt;
  logic       empty;

  int errors = 0;
  int checks = 0;
  int m_q    = 0;
  int m_cnt  = 0;

  univ_shift_reg_sync #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .q(q), .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".q"},      int'(q),      m_q);
    chk({tag, ".cnt"},    int'(cnt),    m_cnt);
    chk({tag, ".empty"},  int'(empty),  (m_cnt == 8) ? 1 : 0);
    chk({tag, ".sout_l"}, int'(sout_l), m_q / 128);
    chk({tag, ".sout_r"}, int'(sout_r), m_q % 2);
  endtask

  // Reference: register held as an integer 0..255, operations as arithmetic.
  function automatic void model(input bit r, input bit e, input int md,
                                input bit sl, input bit sr, input int dd);
    bit shifted = 1'b0;
    if (r) begin
      m_q = 0; m_cnt = 0;
    end else if (e) begin
      case (md)
        1: begin m_q = (m_q * 2 + sr) % 256;                 shifted = 1; end
        2: begin m_q = m_q / 2 + sl * 128;                   shifted = 1; end
        3: begin m_q = dd; m_cnt = 0; end
        4: begin m_q = (m_q * 2) % 256 + m_q / 128;          shifted = 1; end
        5: begin m_q = m_q / 2 + (m_q % 2) * 128;            shifted = 1; end
        6: begin m_q = m_q / 2 + ((m_q >= 128) ? 128 : 0);   shifted = 1; end
        7: begin m_q = 0; m_cnt = 0; end
        default: ;
      endcase
      if (shifted && m_cnt < 8) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic op(input bit r, input bit e, input logic [2:0] md,
                    input bit sl, input bit sr, input logic [7:0] dd,
                    input string tag);
    rst = r; en = e; mode = md; sin_l = sl; sin_r = sr; d = dd;
    model(r, e, int'(md), sl, sr, int'(dd));
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; sin_l = 1'b0; sin_r = 1'b0; d = 8'h00;
    #2;

    // Reset wins over an enabled LOAD.
    op(1, 1, 3'b011, 0, 0, 8'hFF, "reset");
    chk("reset_q_const", int'(q), 8'h00);

    op(0, 1, 3'b011, 0, 0, 8'hA5, "load_a5");
    chk("sout_l_before_shl", int'(sout_l), 1);
    op(0, 1, 3'b001, 0, 1, 8'h00, "shl");
    chk("shl_q_const", int'(q), 8'h4B);
    chk("shl_cnt_const", int'(cnt), 1);

    op(0, 1, 3'b011, 0, 0, 8'h81, "load_81");
    op(0, 1, 3'b101, 0, 0, 8'h00, "rotr");
    chk("rotr_q_const", int'(q), 8'hC0);

    op(0, 1, 3'b011, 0, 0, 8'h90, "load_90");
    op(0, 1, 3'b110, 0, 0, 8'h00, "ashr1");
    chk("ashr1_const", int'(q), 8'hC8);
    op(0, 1, 3'b110, 0, 0, 8'h00, "ashr2");
    chk("ashr2_const", int'(q), 8'hE4);
    op(0, 1, 3'b110, 0, 0, 8'h00, "ashr3");
    chk("ashr3_const", int'(q), 8'hF2);
    op(0, 1, 3'b110, 0, 0, 8'h00, "ashr4");
    chk("ashr4_const", int'(q), 8'hF9);
    chk("ashr4_cnt_const", int'(cnt), 4);

    op(0, 1, 3'b011, 0, 0, 8'h01, "load_01");
    for (int i = 1; i <= 10; i++) begin
      op(0, 1, 3'b001, 0, 0, 8'h00, $sformatf("sat_shl%0d", i));
      chk($sformatf("sat_empty%0d", i), int'(empty), (i >= 8) ? 1 : 0);
    end
    chk("sat_cnt_const", int'(cnt), 8);
    chk("sat_q_const", int'(q), 8'h00);
    op(0, 1, 3'b011, 0, 0, 8'h3C, "load_after_empty");
    chk("reload_empty_const", int'(empty), 0);

    op(0, 1, 3'b011, 0, 0, 8'h02, "load_02");
    op(0, 0, 3'b111, 0, 0, 8'h55, "en0_clr");
    op(0, 0, 3'b011, 0, 0, 8'h55, "en0_load");
    op(0, 0, 3'bxxx, 0, 0, 8'h55, "en0_xmode");
    chk("en0_q_const", int'(q), 8'h02);
    op(0, 1, 3'b010, 1, 0, 8'h00, "shr");
    chk("shr_q_const", int'(q), 8'h81);

    // Reset raised between edges must wait for the next rising edge.
    op(0, 1, 3'b011, 0, 0, 8'hC3, "load_c3");
    op(0, 1, 3'b001, 0, 1, 8'h00, "pre_rst_shl");
    #3 rst = 1'b1;
    #1 chk("rst_midcycle_q", int'(q), m_q);
    chk("rst_midcycle_cnt", int'(cnt), m_cnt);
    model(1, 1, 1, 0, 1, 0);
    @(posedge clk);
    #1 chk_all("rst_edge");
    chk("rst_edge_q_const", int'(q), 8'h00);
    op(0, 1, 3'b001, 0, 1, 8'h00, "resume_shl");
    chk("resume_q_const", int'(q), 8'h01);

    for (int i = 0; i < 400; i++) begin
      op(($urandom_range(0, 39) == 0),
         ($urandom_range(0, 4) != 0),
         3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)),
         8'($urandom_range(0, 255)),
         $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_sync.md
# univ_shift_reg_sync

Parametrised universal shift register with synchronous reset. It succeeds the team's single-bit storage elements, the D latch and D flop, with a WIDTH-bit edge-triggered register. The register supports hold, logical shift, arithmetic shift, rotate, parallel load and clear modes, and tracks a saturating shift counter. It is used as a serialiser/deserialiser stage and as a general-purpose shifting datapath register.

## Interface

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q by reset and by the CLR mode.

Ports:
- clk  input  1  rising-edge clock; all state changes occur on this edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  operation enable; when 0 the register holds.
- mode  input  3  operation select (see Operation).
- sin_l  input  1  serial input, shifted into the MSB on right shifts.
- sin_r  input  1  serial input, shifted into the LSB on left shifts.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- cnt  output  CW  shifts since the last load, clear or reset. CW = $clog2(WIDTH+1). Saturates at WIDTH.
- empty  output  1  asserted when cnt == WIDTH, meaning every loaded bit has left through a shift.

## Operation

Priority per clock edge: rst, then en=0, then mode.
- rst=1: q <= RST_VAL and cnt <= 0. en and mode are ignored.
- en=0: q and cnt hold.

Mode encodings when en=1:
- 000 HOLD: q and cnt hold.
- 001 SHL: q <= {q[WIDTH-2:0], sin_r}.
- 010 SHR: q <= {sin_l, q[WIDTH-1:1]}.
- 011 LOAD: q <= d; cnt <= 0.
- 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 101 ROTR: q <= {q[0], q[WIDTH-1:1]}.
- 110 ASHR: q <= {q[WIDTH-1], q[WIDTH-1:1]}. The sign bit is replicated and sin_l is ignored.
- 111 CLR: q <= RST_VAL; cnt <= 0.

Counter rules:
- cnt increments by 1 on every SHL, SHR, ROTL, ROTR and ASHR.
- When cnt == WIDTH it holds at WIDTH; there is no wrap-around.
- HOLD leaves cnt unchanged.

Flags and outputs:
- empty = (cnt == WIDTH), decoded combinationally from cnt.
- Rotates still count, so empty means "WIDTH positions moved", not "data lost".

Boundary conditions:
- rst together with en=1 and mode=LOAD: the reset wins and d is not loaded.
- A shift issued while cnt == WIDTH still shifts q; cnt stays at WIDTH.
- LOAD issued while empty=1 clears empty on the next edge.
- X on mode while en=0 must not corrupt state; the mode decode is gated by en.

Reset values: q = RST_VAL, sout_l = RST_VAL[WIDTH-1], sout_r = RST_VAL[0], cnt = 0, empty = 0.

## Timing

- Latency is one cycle: the result of an operation sampled at edge N is visible on q, cnt and empty after edge N.
- sout_l and sout_r are valid in the same cycle as q. The bit shifted out by an SHL at edge N is sout_l before edge N.
- The reset is synchronous: asserting rst between edges has no effect until the next rising clk edge. Releasing rst takes effect at the following edge.
- No combinational path exists from inputs to outputs. Every output depends only on registered state.
- A new operation may be issued every cycle. There is no handshake and no busy state.

## Structure

- Shared package usr_pkg:
  - mode localparams MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROTL, MODE_ROTR, MODE_ASHR, MODE_CLR;
  - function cnt_width(WIDTH), returning $clog2(WIDTH+1).
- One sub-module is natural: sat_counter, a parametrised saturating up-counter with synchronous clear and increment. It is reused for cnt.
- The data path is a single always block, clocked on the rising edge, with a case on mode.

## Test plan

All scenarios use WIDTH=8 and RST_VAL=8'h00.
- Reset: rst=1 for one edge with en=1, mode=LOAD, d=8'hFF -> q=8'h00, cnt=0, empty=0.
- Left shift: LOAD d=8'hA5, then SHL with sin_r=1 -> q=8'h4B, cnt=1. sout_l was 1 before the edge.
- Rotate right and arithmetic shift:
  - LOAD 8'h81, ROTR -> 8'hC0.
  - LOAD 8'h90, then four ASHR with sin_l=0 -> 8'hC8, 8'hE4, 8'hF2, 8'hF9; cnt=4.
- Saturation: LOAD 8'h01, then ten SHL with sin_r=0 -> empty rises after the 8th edge, cnt stays 8 through edge 10, q=8'h00. A following LOAD 8'h3C -> cnt=0, empty=0.
- Enable gating: en=0 with mode=CLR or LOAD for 3 cycles -> q and cnt unchanged. SHR with sin_l=1 on 8'h02 -> 8'h81.
- Synchronous reset mid-stream: assert rst mid-cycle during a shift sequence -> q unchanged until the next edge, then 8'h00 and cnt=0. Release rst with en=1, mode=SHL -> shifting resumes on the following edge.
